pipe_ctrl: RTL and testbench

- Central pipeline control unit that produces the hold_flag/flush_flag buses consumed by every pipeline register (pc, if_id, id_ex, ex stage).
- Arbitrates redirects (EX jump, interrupt) against stall requests (bus stall, multicycle EX op, load-use hazard).
- Drives the PC redirect and a stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 97 +++++++++
 tb/tb_pipe_ctrl.sv | 97 +++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hold/flush arbitration, PC redirect and stall-cycle counter
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int LU_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        int_assert_i,
  input  logic [31:0] int_addr_i,
  output logic        int_ack_o,
  input  logic        hold_bus_req_i,
  input  logic        hold_ex_req_i,
  input  logic        load_use_i,
  output logic [2:0]  hold_flag_o,
  output logic [2:0]  flush_flag_o,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [31:0] stall_cnt_o
);
  typedef enum logic [1:0] {IDLE, REDIR, PEND, LU} state_t;
  localparam logic [2:0] HOLD_ID = 3'd3, HOLD_EX = 3'd4, FLUSH_EX = 3'd3;
  localparam logic [2:0] F_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [1:0] L_INIT = 2'(LU_CYCLES - 1);
  state_t state, state_n;
  logic [31:0] pend_addr, pend_addr_n;
  logic [2:0] fcnt, fcnt_n;
  logic [1:0] lcnt, lcnt_n;
  always_comb begin
    state_n = state;
    pend_addr_n = pend_addr;
    fcnt_n = fcnt;
    lcnt_n = lcnt;
    hold_flag_o = 3'd0;
    flush_flag_o = 3'd0;
    jump_flag_o = 1'b0;
    jump_addr_o = 32'd0;
    int_ack_o = 1'b0;
    if (int_assert_i && !hold_bus_req_i) begin
      int_ack_o = 1'b1;
      jump_flag_o = 1'b1;
      jump_addr_o = int_addr_i;
      flush_flag_o = FLUSH_EX;
      state_n = REDIR;
      fcnt_n = F_INIT;
    end else if (hold_bus_req_i) begin
      hold_flag_o = HOLD_EX;
      if (jump_flag_i && state != PEND) begin
        pend_addr_n = jump_addr_i;
        state_n = PEND;
      end
    end else if (state == PEND) begin
      // the jump still sitting in EX is the one already latched
      jump_flag_o = 1'b1;
      jump_addr_o = pend_addr;
      flush_flag_o = FLUSH_EX;
      state_n = REDIR;
      fcnt_n = F_INIT;
    end else if (jump_flag_i) begin
      jump_flag_o = 1'b1;
      jump_addr_o = jump_addr_i;
      flush_flag_o = FLUSH_EX;
      state_n = REDIR;
      fcnt_n = F_INIT;
    end else if (hold_ex_req_i) begin
      hold_flag_o = HOLD_EX;
    end else if (state == REDIR) begin
      flush_flag_o = fcnt != 3'd0 ? FLUSH_EX : 3'd0;
      fcnt_n = fcnt != 3'd0 ? fcnt - 3'd1 : fcnt;
      state_n = fcnt != 3'd0 ? REDIR : IDLE;
    end else if (state == LU) begin
      hold_flag_o = lcnt != 2'd0 ? HOLD_ID : 3'd0;
      lcnt_n = lcnt != 2'd0 ? lcnt - 2'd1 : lcnt;
      state_n = lcnt != 2'd0 ? LU : IDLE;
    end else if (load_use_i) begin
      hold_flag_o = HOLD_ID;
      state_n = LU;
      lcnt_n = L_INIT;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend_addr <= 32'd0;
      fcnt <= 3'd0;
      lcnt <= 2'd0;
      stall_cnt_o <= 32'd0;
    end else begin
      state <= state_n;
      pend_addr <= pend_addr_n;
      fcnt <= fcnt_n;
      lcnt <= lcnt_n;
      if (hold_flag_o != 3'd0 && stall_cnt_o != 32'hFFFF_FFFF) stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scoreboard bench for pipe_ctrl (FLUSH_CYCLES=2, LU_CYCLES=1)
module tb_pipe_ctrl;
  logic clk = 1'b0;
  logic rst, jump_flag_i, int_assert_i, hold_bus_req_i, hold_ex_req_i, load_use_i;
  logic [31:0] jump_addr_i, int_addr_i;
  logic int_ack_o, jump_flag_o;
  logic [2:0] hold_flag_o, flush_flag_o;
  logic [31:0] jump_addr_o, stall_cnt_o;
  typedef struct {
    logic [2:0] hold;
    logic [2:0] flush;
    logic jf;
    logic [31:0] ja;
    logic ack;
    logic [31:0] sc;
  } exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;
  logic [31:0] exp_sc = 0;
  always #5 clk = ~clk;
  pipe_ctrl #(.FLUSH_CYCLES(2), .LU_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .int_assert_i(int_assert_i), .int_addr_i(int_addr_i), .int_ack_o(int_ack_o),
    .hold_bus_req_i(hold_bus_req_i), .hold_ex_req_i(hold_ex_req_i), .load_use_i(load_use_i),
    .hold_flag_o(hold_flag_o), .flush_flag_o(flush_flag_o),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .stall_cnt_o(stall_cnt_o)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step(input string tag, input logic ji, input logic [31:0] ja, input logic ii,
                      input logic [31:0] ia, input logic bus, input logic ex, input logic lu,
                      input logic [2:0] hold, input logic [2:0] flush, input logic jf,
                      input logic [31:0] jao, input logic ack);
    exp_t e, o;
    jump_flag_i = ji; jump_addr_i = ja; int_assert_i = ii; int_addr_i = ia;
    hold_bus_req_i = bus; hold_ex_req_i = ex; load_use_i = lu;
    e.hold = hold; e.flush = flush; e.jf = jf; e.ja = jao; e.ack = ack; e.sc = exp_sc;
    sb.push_back(e);
    @(negedge clk);
    o = sb.pop_front();
    chk({tag, ".hold"}, 32'(hold_flag_o), 32'(o.hold));
    chk({tag, ".flush"}, 32'(flush_flag_o), 32'(o.flush));
    chk({tag, ".jf"}, 32'(jump_flag_o), 32'(o.jf));
    chk({tag, ".ja"}, jump_addr_o, o.ja);
    chk({tag, ".ack"}, 32'(int_ack_o), 32'(o.ack));
    chk({tag, ".scnt"}, stall_cnt_o, o.sc);
    if (hold != 3'd0) exp_sc++;
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input string tag, input logic [2:0] flush);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, flush, 0, 0, 0);
  endtask
  initial begin
    rst = 1; jump_flag_i = 0; jump_addr_i = 0; int_assert_i = 0; int_addr_i = 0;
    hold_bus_req_i = 0; hold_ex_req_i = 0; load_use_i = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0; load_use_i = 0;
    idle("reset", 0);
    step("jump", 1, 32'h100, 0, 0, 0, 0, 0, 0, 3, 1, 32'h100, 0);
    idle("jump_fl1", 3);
    idle("jump_fl0", 0);
    idle("jump_idle", 0);
    step("lu", 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0);
    idle("lu_end", 0);
    idle("lu_cnt", 0);
    for (int i = 0; i < 3; i++) step("bus_jump", 1, 32'h200, 0, 0, 1, 0, 0, 4, 0, 0, 0, 0);
    step("bus_rel", 1, 32'h200, 0, 0, 0, 0, 0, 0, 3, 1, 32'h200, 0);
    idle("bus_fl1", 3);
    idle("bus_fl0", 0);
    step("int_jump", 1, 32'h300, 1, 32'h80, 0, 0, 0, 0, 3, 1, 32'h80, 1);
    idle("int_fl1", 3);
    idle("int_fl0", 0);
    idle("int_nojump", 0);
    for (int i = 0; i < 2; i++) step("int_bus", 0, 0, 1, 32'h80, 1, 0, 0, 4, 0, 0, 0, 0);
    step("int_take", 0, 0, 1, 32'h80, 0, 0, 0, 0, 3, 1, 32'h80, 1);
    for (int i = 0; i < 2; i++) step("ex_busy", 0, 0, 0, 0, 0, 1, 0, 4, 0, 0, 0, 0);
    idle("ex_fl1", 3);
    idle("ex_fl0", 0);
    idle("ex_idle", 0);
    step("pend_pre", 1, 32'h400, 0, 0, 1, 0, 0, 4, 0, 0, 0, 0);
    rst = 1;
    @(posedge clk);
    #1 rst = 0; hold_bus_req_i = 0; jump_flag_i = 0;
    exp_sc = 0;
    idle("rst_mid", 0);
    idle("rst_mid2", 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
